// File: rtl/mimo_pkg.sv
// mimo_pkg: shared dimensions, PAM4 Gray-map constants and controller states for the MIMO TX mapper.
package mimo_pkg;
    localparam int NT = 8;
    localparam int RW = 12;
    localparam int AW = 18;
    localparam logic signed [2:0] PAM4_M3 = -3'sd3;
    localparam logic signed [2:0] PAM4_M1 = -3'sd1;
    localparam logic signed [2:0] PAM4_P1 = 3'sd1;
    localparam logic signed [2:0] PAM4_P3 = 3'sd3;
    typedef enum logic [1:0] {COLLECT, CALC, OUT} state_t;
endpackage

// File: rtl/mimo_pam4_map.sv
// mimo_pam4_map: Gray-coded 2-bit PAM4 code to signed symbol (00->-3, 01->-1, 11->+1, 10->+3).
module mimo_pam4_map import mimo_pkg::*; (
    input  logic [1:0]        code,
    output logic signed [2:0] sym
);
    assign sym = (code == 2'b00) ? PAM4_M3 :
                 (code == 2'b01) ? PAM4_M1 :
                 (code == 2'b11) ? PAM4_P1 : PAM4_P3;
endmodule

// File: rtl/mimo_tx_mapper.sv
// mimo_tx_mapper: collects 8 PAM4 symbols, emits y = R*s row by row (7..0) with an upper-triangular R.
// Optional LFSR dither on y is enabled by defining MIMO_TX_NOISE_EN.
module mimo_tx_mapper #(
    parameter int NT = 8,
    parameter int RW = 12,
    parameter int AW = 18
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic [3:0]           bit_data,
    input  logic                 r_wr_en,
    input  logic [5:0]           r_wr_addr,
    input  logic signed [RW-1:0] r_wr_data,
    output logic                 r_wr_err,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [2:0]           y_idx,
    output logic signed [RW-1:0] y_data,
    output logic signed [2:0]    y_sym,
    output logic                 y_last
);
    import mimo_pkg::*;
    localparam int YMAX = 2 ** (RW - 1) - 1;
    localparam int YMIN = -(2 ** (RW - 1));
    state_t state, state_nx;
    logic [1:0] beat;
    logic [2:0] row, col;
    logic signed [RW-1:0] r_mem [NT*NT];
    logic signed [2:0] s [NT];
    logic signed [2:0] sym_lo, sym_hi;
    logic signed [AW-1:0] acc, acc_nx, noise, y_full;
    logic signed [RW-1:0] y_sat;
    logic beat_take, out_take, row_done, wr_ok;

    mimo_pam4_map u_map_lo (.code(bit_data[1:0]), .sym(sym_lo));
    mimo_pam4_map u_map_hi (.code(bit_data[3:2]), .sym(sym_hi));

    assign bit_ready = state == COLLECT;
    assign y_valid = state == OUT;
    assign y_last = y_valid && row == 3'd0;
    assign y_idx = row;
    assign beat_take = bit_valid && bit_ready;
    assign out_take = y_valid && y_ready;
    assign row_done = col == 3'd7;
    assign wr_ok = state == COLLECT && r_wr_addr[5:3] <= r_wr_addr[2:0];
    assign acc_nx = acc + AW'(r_mem[{row, col}]) * AW'(s[col]);
    assign y_full = acc_nx + noise;
    assign y_sat = (y_full > AW'(YMAX)) ? RW'(YMAX) :
                   (y_full < AW'(YMIN)) ? RW'(YMIN) : y_full[RW-1:0];

`ifdef MIMO_TX_NOISE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr <= 16'hACE1;
        else if (out_take) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign noise = AW'(signed'(lfsr[3:0]));
`else
    assign noise = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= COLLECT;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == COLLECT && beat_take && beat == 2'd3) state_nx = CALC;
        if (state == CALC && row_done) state_nx = OUT;
        if (out_take) state_nx = (row == 3'd0) ? COLLECT : CALC;
    end

    // Row i walks col i..7; the next row restarts on its own diagonal.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat <= '0;
            row <= 3'd7;
            col <= 3'd7;
            acc <= '0;
            y_data <= '0;
            y_sym <= '0;
            for (int i = 0; i < NT; i++) s[i] <= '0;
        end else begin
            if (beat_take) begin
                beat <= beat + 2'd1;
                s[{beat, 1'b0}] <= sym_lo;
                s[{beat, 1'b1}] <= sym_hi;
            end
            if (state == CALC) begin
                acc <= row_done ? '0 : acc_nx;
                col <= row_done ? col : col + 3'd1;
                if (row_done) begin
                    y_data <= y_sat;
                    y_sym <= s[row];
                end
            end
            if (out_take) begin
                row <= row - 3'd1;
                col <= row - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_err <= 1'b0;
            for (int i = 0; i < NT * NT; i++) r_mem[i] <= '0;
        end else begin
            r_wr_err <= r_wr_en && !wr_ok;
            if (r_wr_en && wr_ok) r_mem[r_wr_addr] <= r_wr_data;
        end
    end
endmodule

// File: tb/tb_mimo_tx_mapper.sv
// tb_mimo_tx_mapper: directed vectors with hand-computed y values for mimo_tx_mapper (noise disabled).
module tb_mimo_tx_mapper;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_ready;
    logic [3:0] bit_data = '0;
    logic r_wr_en = 1'b0;
    logic [5:0] r_wr_addr = '0;
    logic signed [11:0] r_wr_data = '0;
    logic r_wr_err;
    logic y_valid;
    logic y_ready = 1'b0;
    logic [2:0] y_idx;
    logic signed [11:0] y_data;
    logic signed [2:0] y_sym;
    logic y_last;
    int n_cmp = 0;
    int n_err = 0;

    mimo_tx_mapper dut (
        .clk(clk), .rstn(rstn),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_data(bit_data),
        .r_wr_en(r_wr_en), .r_wr_addr(r_wr_addr), .r_wr_data(r_wr_data), .r_wr_err(r_wr_err),
        .y_valid(y_valid), .y_ready(y_ready), .y_idx(y_idx), .y_data(y_data),
        .y_sym(y_sym), .y_last(y_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input int data);
        r_wr_en = 1'b1;
        r_wr_addr = 6'(addr);
        r_wr_data = 12'(data);
        @(negedge clk);
        r_wr_en = 1'b0;
    endtask

    task automatic send_vec(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2, input logic [3:0] b3);
        logic [3:0] b [4];
        b = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_data = b[i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    task automatic expect_beat(input int idx, input int data, input int sym, input int last);
        for (int k = 0; k < 100 && y_valid !== 1'b1; k++) @(negedge clk);
        chk("y_valid", y_valid, 1);
        chk("y_idx", y_idx, idx);
        chk("y_data", y_data, data);
        chk("y_sym", y_sym, sym);
        chk("y_last", y_last, last);
        chk("bit_ready_in_out", bit_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_idx", y_idx, 7);
        chk("rst_y_data", y_data, 0);
        chk("rst_y_sym", y_sym, 0);
        chk("rst_y_last", y_last, 0);
        chk("rst_r_wr_err", r_wr_err, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_bit_ready", bit_ready, 1);

        // R[7][7]=5, s7=-1: first beat -5 two cycles after the 4th beat
        y_ready = 1'b1;
        wr(63, 5);
        send_vec(4'b0000, 4'b0000, 4'b0000, 4'b0100);
        chk("lat_cycle1_valid", y_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", y_valid, 1);
        expect_beat(7, -5, -1, 0);
        for (int i = 6; i >= 0; i--) expect_beat(i, 0, -3, i == 0);

        // diagonal 100, all +3; a write during CALC is dropped
        y_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(i * 9, 100);
        send_vec(4'b1010, 4'b1010, 4'b1010, 4'b1010);
        wr(0, 55);
        chk("err_calc_pulse", r_wr_err, 1);
        @(negedge clk);
        chk("err_calc_clear", r_wr_err, 0);
        y_ready = 1'b1;
        for (int i = 7; i >= 0; i--) expect_beat(i, 300, 3, i == 0);
        chk("bit_ready_back", bit_ready, 1);

        // lower-triangle write in COLLECT
        wr(8, 77);
        chk("err_lower_pulse", r_wr_err, 1);
        @(negedge clk);
        chk("err_lower_clear", r_wr_err, 0);

        // stall on row 3; R[0][0] must still be 100
        send_vec(4'b1010, 4'b1010, 4'b1010, 4'b1010);
        for (int i = 7; i >= 4; i--) expect_beat(i, 300, 3, 0);
        y_ready = 1'b0;
        for (int k = 0; k < 50 && y_valid !== 1'b1; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", y_valid, 1);
            chk("stall_idx", y_idx, 3);
            chk("stall_data", y_data, 300);
            chk("stall_bit_ready", bit_ready, 0);
            @(negedge clk);
        end
        y_ready = 1'b1;
        for (int i = 3; i >= 0; i--) expect_beat(i, 300, 3, i == 0);

        // full upper triangle 2047: positive and negative saturation
        for (int r = 0; r < 8; r++)
            for (int c = r; c < 8; c++) wr(r * 8 + c, 2047);
        send_vec(4'b1010, 4'b1010, 4'b1010, 4'b1010);
        for (int i = 7; i >= 0; i--) expect_beat(i, 2047, 3, i == 0);
        send_vec(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 7; i >= 0; i--) expect_beat(i, -2048, -3, i == 0);

        // reset mid-CALC discards the vector and clears R
        send_vec(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_y_valid", y_valid, 0);
        chk("midrst_bit_ready", bit_ready, 1);
        chk("midrst_y_idx", y_idx, 7);
        chk("midrst_y_data", y_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst_no_beat", y_valid, 0);
        end

        // mixed R and symbols after reset
        wr(45, 10);
        wr(46, -7);
        wr(47, 3);
        wr(63, -20);
        wr(54, 1);
        wr(0, 100);
        wr(7, -1000);
        send_vec(4'b0010, 4'b1101, 4'b1110, 4'b1001);
        expect_beat(7, -60, 3, 0);
        expect_beat(6, -1, -1, 0);
        expect_beat(5, 26, 1, 0);
        expect_beat(4, 0, 3, 0);
        expect_beat(3, 0, 1, 0);
        expect_beat(2, 0, -1, 0);
        expect_beat(1, 0, -3, 0);
        expect_beat(0, -2048, 3, 1);
        chk("final_bit_ready", bit_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mimo_tx_mapper.md
MIMO_TX_MAPPER -- requirements
Module: mimo_tx_mapper

Interface
REQ-001 Parameter NT, 8: number of real dimensions (4x4 16-QAM, real-decomposed).
REQ-002 Parameter RW, 12: signed width of R coefficients and of the y output.
REQ-003 Parameter AW, 18: signed accumulator width.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rstn, input, 1: asynchronous, active-low reset.
REQ-006 Port bit_valid / bit_ready, input / output, 1 / 1: payload handshake.
REQ-007 Port bit_data, input, 4: two PAM4 symbols per beat; bits [1:0] map to the lower dimension.
REQ-008 Port r_wr_en / r_wr_addr / r_wr_data, input, 1 / 6 / RW signed: R-matrix write, addr = row*8+col.
REQ-009 Port r_wr_err, output, 1: one-cycle pulse when a write is dropped.
REQ-010 Port y_valid / y_ready, output / input, 1 / 1: y output handshake.
REQ-011 Port y_idx / y_data / y_sym, output, 3 / RW signed / 3 signed: row index, y value, and symbol of that row.
REQ-012 Port y_last, output, 1: high on the beat with y_idx=0.

Function
REQ-013 PAM4 Gray map: 00->-3, 01->-1, 11->+1, 10->+3.
REQ-014 COLLECT: bit_ready=1; 4 accepted beats fill s[0..7] in ascending order; the 4th beat moves the block to CALC.
REQ-015 CALC row i: y_i = sum over j=i..7 of R[i][j]*s[j], one MAC per cycle, (8-i) cycles; the lower triangle is never read.
REQ-016 Rows are processed 7 down to 0, matching detector layer order.
REQ-017 Accumulation is exact in AW bits; the result saturates to the signed RW range [-2048, 2047].
REQ-018 OUT: y_valid=1 with stable y_idx, y_data, y_sym until y_ready; after the handshake, go to CALC for row i-1, or to COLLECT after row 0.
REQ-019 State sequence: COLLECT -> CALC -> OUT -> (CALC | COLLECT); the state machine has no other states.
REQ-020 bit_ready=0 in CALC and OUT, including the cycle of the final y handshake; bit_ready returns to 1 on the next cycle.
REQ-021 R writes are accepted only in COLLECT; writes in CALC or OUT are dropped and pulse r_wr_err the following cycle.
REQ-022 An R write to a lower-triangle address (row>col) is dropped and pulses r_wr_err.
REQ-023 Latency from the 4th bit beat to the first y_valid is 2 cycles (CALC row 7 is 1 MAC plus the OUT register).
REQ-024 With y_ready held at 1, one vector completes in 44 cycles (36 MAC + 8 OUT).

Reset
REQ-025 On rstn low: state=COLLECT, bit_ready=1 after release, y_valid=0, y_idx=7, y_data=0, y_sym=0, y_last=0, r_wr_err=0.
REQ-026 On rstn low: R array cleared to 0, s buffer and beat counter cleared.
REQ-027 A reset during CALC or OUT discards the partial vector; no y beat is emitted for it.

Configuration
REQ-028 Macro MIMO_TX_NOISE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances once per OUT handshake.
REQ-029 With MIMO_TX_NOISE_EN defined: the sign-extended lfsr[3:0] (-8..7) is added to y before saturation.
REQ-030 Macro MIMO_TX_NOISE_EN undefined: no LFSR is instantiated and y is noiseless.

Structure
REQ-031 Shared package mimo_pkg holds NT, RW, AW, the PAM4 map constants and the state enum.
REQ-032 Sub-module mimo_pam4_map (2-bit code -> 3-bit signed symbol) is the only sub-module and is reused by the detector test bench.

Verification
REQ-033 R diagonal=100, others 0, all bit_data=4'b1010 -> 8 beats, each y_data=300, y_sym=+3, y_idx 7..0, y_last on the final beat.
REQ-034 Row 7 R[7][7]=5, bits giving s7=-1 -> first beat y_idx=7, y_data=-5, 2 cycles after the 4th bit beat.
REQ-035 All upper-triangle R=2047, all symbols +3 -> rows 0..6 y_data=2047 (saturated); row 7 y_data=2047 (6141 clipped).
REQ-036 r_wr_en during CALC, and a write to addr 8 (row1,col0) in COLLECT -> r_wr_err pulses twice; R is unchanged.
REQ-037 y_ready held low 10 cycles on row 3 -> outputs stable and bit_ready=0 throughout; release -> row 2 follows.
REQ-038 rstn asserted mid-CALC -> y_valid=0 immediately; a new 4-beat vector produces a correct full 8-beat output.
